// File: rtl/rv_skid_pkg.sv
// rtl/rv_skid_pkg.sv - sizing and pointer helpers shared by the rv skid buffer files
package rv_skid_pkg;

   function automatic int calc_cap(input int depth);
      return depth + 1;
   endfunction

   // Level must represent 0..CAP inclusive, hence DEPTH+2 codes.
   function automatic int calc_lvl_w(input int depth);
      return $clog2(depth + 2);
   endfunction

   function automatic int calc_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rv_skid_fifo_if.sv
// rtl/rv_skid_fifo_if.sv - ready/valid upstream and downstream bundle; flush exists only with RV_SKID_FLUSH_EN
interface rv_skid_fifo_if
   import rv_skid_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
);
   localparam int LVL_W = calc_lvl_w(DEPTH);

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [LVL_W-1:0]  level;
`ifdef RV_SKID_FLUSH_EN
   logic              flush;

   modport master (output s_valid, s_data, m_ready, flush,
                   input  s_ready, m_valid, m_data, level);
   modport slave  (input  s_valid, s_data, m_ready, flush,
                   output s_ready, m_valid, m_data, level);
`else
   modport master (output s_valid, s_data, m_ready,
                   input  s_ready, m_valid, m_data, level);
   modport slave  (input  s_valid, s_data, m_ready,
                   output s_ready, m_valid, m_data, level);
`endif
endinterface

// File: rtl/rv_skid_mem.sv
// rtl/rv_skid_mem.sv - DEPTH x DATA_W skid store, synchronous write, asynchronous read
module rv_skid_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2,
   parameter int PTR_W  = 1
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [PTR_W-1:0]  wr_ptr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [PTR_W-1:0]  rd_ptr_i,
   output logic [DATA_W-1:0] rd_data_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_i] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/rv_skid_fifo.sv
// rtl/rv_skid_fifo.sv - registered-output ready/valid skid FIFO; optional flush via RV_SKID_FLUSH_EN
module rv_skid_fifo
   import rv_skid_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input logic          clk,
   input logic          rst_n,
   rv_skid_fifo_if.slave bus
);
   localparam int CAP   = calc_cap(DEPTH);
   localparam int LVL_W = calc_lvl_w(DEPTH);
   localparam int PTR_W = calc_ptr_w(DEPTH);

   typedef logic [LVL_W-1:0] level_t;
   typedef logic [PTR_W-1:0] ptr_t;

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic              s_ready_q, s_ready_d;
   level_t            level_q,   level_d;
   ptr_t              wr_ptr_q,  wr_ptr_d;
   ptr_t              rd_ptr_q,  rd_ptr_d;
   logic              wr_en;
   logic [DATA_W-1:0] skid_head;
   logic              accept, pop, skid_empty, direct;

   assign accept     = bus.s_valid & s_ready_q;
   assign pop        = m_valid_q & bus.m_ready;
   assign skid_empty = ((level_q - level_t'(m_valid_q)) == '0);
   // Bypass the skid store only when ordering cannot be violated.
   assign direct     = (!m_valid_q || pop) && skid_empty;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_en     = 1'b0;
      level_d   = level_q + level_t'(accept) - level_t'(pop);

      if (pop && !skid_empty) begin
         m_data_d  = skid_head;
         m_valid_d = 1'b1;
         rd_ptr_d  = ptr_t'(ptr_inc(int'(rd_ptr_q), DEPTH));
      end else if (accept && direct) begin
         m_data_d  = bus.s_data;
         m_valid_d = 1'b1;
      end else if (pop) begin
         m_valid_d = 1'b0;
      end

      if (accept && !direct) begin
         wr_en    = 1'b1;
         wr_ptr_d = ptr_t'(ptr_inc(int'(wr_ptr_q), DEPTH));
      end

`ifdef RV_SKID_FLUSH_EN
      if (bus.flush) begin
         m_valid_d = 1'b0;
         level_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         wr_en     = 1'b0;
      end
`endif
      s_ready_d = (level_d < level_t'(CAP));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_ready_q <= 1'b0;
         level_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         s_ready_q <= s_ready_d;
         level_q   <= level_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   rv_skid_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_ptr_i  (wr_ptr_q),
      .wr_data_i (bus.s_data),
      .rd_ptr_i  (rd_ptr_q),
      .rd_data_o (skid_head)
   );

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.s_ready = s_ready_q;
   assign bus.level   = level_q;
endmodule

// File: tb/tb_rv_skid_fifo.sv
// tb/tb_rv_skid_fifo.sv - directed vectors, stream, mid-stream reset, random scoreboard; flush with RV_SKID_FLUSH_EN
module tb_rv_skid_fifo;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   rv_skid_fifo_if #(.DATA_W(8), .DEPTH(2)) bus ();

   rv_skid_fifo #(.DATA_W(8), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       mr;
      logic       e_sr;
      logic       e_mv;
      logic [7:0] e_md;
      logic [1:0] e_lvl;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q [$];
   logic       cur_v, acc, pp, stall, prev_stall;
   logic [7:0] cur_d, prev_md;

   initial begin
      // single beat, fill/hold/drain, accept+pop with skid busy, stall hold
      vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
      vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1};
      vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2};
      vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
      vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
      vecs[6]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h02, 2'd2};
      vecs[7]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h03, 2'd2};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2'd1};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
      vecs[10] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 2'd1};
      vecs[11] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 2'd2};
      vecs[12] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2};
      vecs[13] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2'd2};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 2'd1};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
      vecs[17] = '{1'b1, 8'h7E, 1'b0, 1'b1, 1'b1, 8'h7E, 2'd1};
      vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7E, 2'd1};
      vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.m_ready = 1'b0;
`ifdef RV_SKID_FLUSH_EN
      bus.flush   = 1'b0;
`endif
      repeat (2) tick();
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data",  32'(bus.m_data),  32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_level",   32'(bus.level),   32'd0);

      rst_n = 1'b1;
      tick();
      chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
      chk("rel_level",   32'(bus.level),   32'd0);

      foreach (vecs[i]) begin
         bus.s_valid = vecs[i].sv;
         bus.s_data  = vecs[i].sd;
         bus.m_ready = vecs[i].mr;
         tick();
         chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(vecs[i].e_sr));
         chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(vecs[i].e_mv));
         chk($sformatf("vec%0d_level", i),   32'(bus.level),   32'(vecs[i].e_lvl));
         if (vecs[i].e_mv)
            chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(vecs[i].e_md));
      end

      // Back-to-back streaming at one beat per cycle
      for (int i = 0; i < 100; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i);
         bus.m_ready = 1'b1;
         tick();
         chk("stream_m_valid", 32'(bus.m_valid), 32'd1);
         chk("stream_m_data",  32'(bus.m_data),  32'(i));
         chk("stream_s_ready", 32'(bus.s_ready), 32'd1);
         chk("stream_level",   32'(bus.level),   32'd1);
      end
      bus.s_valid = 1'b0;
      tick();
      chk("stream_end_level", 32'(bus.level), 32'd0);

      // Asynchronous reset with data held
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hC1;
      tick();
      bus.s_data  = 8'hC2;
      tick();
      chk("pre_arst_level", 32'(bus.level), 32'd2);
      bus.s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("arst_m_data",  32'(bus.m_data),  32'd0);
      chk("arst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("arst_level",   32'(bus.level),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_rel_s_ready", 32'(bus.s_ready), 32'd1);
      chk("arst_rel_m_valid", 32'(bus.m_valid), 32'd0);

      // Random traffic against a queue model
      cur_v      = 1'b0;
      cur_d      = 8'h00;
      prev_stall = 1'b0;
      prev_md    = 8'h00;
      for (int c = 0; c < 10000; c++) begin
         if (!cur_v) begin
            cur_v = ($urandom_range(0, 3) != 0);
            cur_d = 8'($urandom);
         end
         bus.s_valid = cur_v;
         bus.s_data  = cur_d;
         bus.m_ready = ($urandom_range(0, 2) != 0);
         acc   = cur_v && (q.size() < 3);
         pp    = bus.m_ready && (q.size() > 0);
         stall = (q.size() > 0) && !bus.m_ready;
         prev_md = bus.m_data;
         tick();
         if (pp) void'(q.pop_front());
         if (acc) begin
            q.push_back(cur_d);
            cur_v = 1'b0;
         end
         chk("rnd_m_valid", 32'(bus.m_valid), 32'(q.size() > 0));
         chk("rnd_level",   32'(bus.level),   32'(q.size()));
         chk("rnd_s_ready", 32'(bus.s_ready), 32'(q.size() < 3));
         if (q.size() > 0) chk("rnd_m_data", 32'(bus.m_data), 32'(q[0]));
         if (stall) chk("rnd_stall_hold", 32'(bus.m_data), 32'(prev_md));
         prev_stall = stall;
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      repeat (4) tick();
      chk("rnd_drain_level", 32'(bus.level), 32'd0);

`ifdef RV_SKID_FLUSH_EN
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(8'h20 + i);
         tick();
      end
      chk("fl_pre_level", 32'(bus.level), 32'd3);
      bus.s_valid = 1'b0;
      bus.flush   = 1'b1;
      tick();
      bus.flush   = 1'b0;
      chk("fl_m_valid", 32'(bus.m_valid), 32'd0);
      chk("fl_level",   32'(bus.level),   32'd0);
      chk("fl_s_ready", 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h55;
      tick();
      bus.s_valid = 1'b0;
      chk("fl_next_m_valid", 32'(bus.m_valid), 32'd1);
      chk("fl_next_m_data",  32'(bus.m_data),  32'h55);
      chk("fl_next_level",   32'(bus.level),   32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
